// File: rtl/turbo_stream_deframer_pkg.sv
// Shared definitions for the turbo stream deframer: FSM states, block
// geometry defaults, LTE RSC generator taps and the RSC helper functions.
package turbo_stream_deframer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int TAIL_BEATS  = 4;
    localparam int K_SHORT_DEF = 4;
    localparam int K_LONG_DEF  = 6;
    localparam int CNT_W_DEF   = 14;
    localparam int ERR_W_DEF   = 16;

    // Generator polynomials, bit d = coefficient of D^d.
    localparam logic [3:0] RSC_G0 = 4'b1101;  // 1 + D^2 + D^3 (feedback)
    localparam logic [3:0] RSC_G1 = 4'b1011;  // 1 + D + D^3   (parity)

    // State vector layout: st[0]=s1, st[1]=s2, st[2]=s3.
    function automatic logic rsc_feedback(input logic x, input logic [2:0] st);
        return x ^ (^(st & RSC_G0[3:1]));
    endfunction

    function automatic logic rsc_parity(input logic a, input logic [2:0] st);
        return (a & RSC_G1[0]) ^ (^(st & RSC_G1[3:1]));
    endfunction

    // Expected {zkp, zk, xk} for encoder-1 termination beats, from the state
    // left after the last data beat.
    function automatic logic [2:0] rsc_tail_expect(input logic beat1, input logic [2:0] st);
        logic [2:0] exp_v;
        if (beat1) begin
            exp_v = {st[0], st[0], st[1]};
        end else begin
            exp_v = {st[0] ^ st[1], st[0] ^ st[2], st[1] ^ st[2]};
        end
        return exp_v;
    endfunction

endpackage

// File: rtl/turbo_stream_deframer_rsc_checker.sv
// Local copy of constituent encoder 1: tracks the RSC state across data
// beats, flags parity mismatches and termination-beat mismatches.
module turbo_stream_deframer_rsc_checker
    import turbo_stream_deframer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic data_en,
    input  logic tail_chk_en,
    input  logic tail_sel,
    input  logic xk,
    input  logic zk,
    input  logic zkp,
    output logic par_mis,
    output logic tail_mis
);

    logic [2:0] st_r;
    logic [2:0] st_eff_s;
    logic [2:0] st_next_s;
    logic       a_s;

    // Re-encode the current beat; beat 0 of a block starts from the zero state.
    always_comb begin
        st_eff_s  = start ? 3'b000 : st_r;
        a_s       = rsc_feedback(xk, st_eff_s);
        st_next_s = {st_eff_s[1:0], a_s};
        par_mis   = data_en & (zk != rsc_parity(a_s, st_eff_s));
        tail_mis  = tail_chk_en & ({zkp, zk, xk} != rsc_tail_expect(tail_sel, st_r));
    end

    // RSC shift register advances on data beats only; frozen through the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_r <= 3'b000;
        end else if (data_en) begin
            st_r <= st_next_s;
        end else begin
            st_r <= st_r;
        end
    end

endmodule

// File: rtl/turbo_stream_deframer.sv
// Turbo stream deframer: splits each block into K data beats plus 4 tail
// beats, forwards data bits, captures tail bits and reports encoder-1 checks.
module turbo_stream_deframer
    import turbo_stream_deframer_pkg::*;
#(
    parameter int K_SHORT = K_SHORT_DEF,
    parameter int K_LONG  = K_LONG_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int ERR_W   = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             length_flag,
    input  logic             xk,
    input  logic             zk,
    input  logic             zkp,
    output logic             sys_bit,
    output logic             par1_bit,
    output logic             par2_bit,
    output logic             out_valid,
    output logic             sob,
    output logic             eob,
    output logic [11:0]      tail_bits,
    output logic             tail_valid,
    output logic [ERR_W-1:0] par_err_cnt,
    output logic             term_err,
    output logic             block_done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_BEATS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] beat_cnt_r, k_last_r;
    logic             first_s, data_s, tail_s, last_data_s, last_tail_s;
    logic             tail_chk_s, par_mis_s, tail_mis_s;
    logic             sys_r, par1_r, par2_r, out_valid_r, sob_r, eob_r;
    logic [11:0]      tail_bits_r;
    logic             tail_valid_r, term_err_r, block_done_r, busy_r;
    logic [ERR_W-1:0] par_err_cnt_r;

    // Next-state and beat classification; only IDLE/DATA/TAIL consume beats.
    always_comb begin
        state_next_s = state_r;
        first_s      = 1'b0;
        data_s       = 1'b0;
        tail_s       = 1'b0;
        last_data_s  = 1'b0;
        last_tail_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    first_s      = 1'b1;
                    data_s       = 1'b1;
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (in_valid) begin
                    data_s = 1'b1;
                    if (beat_cnt_r == k_last_r) begin
                        last_data_s  = 1'b1;
                        state_next_s = ST_TAIL;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_TAIL: begin
                if (in_valid) begin
                    tail_s = 1'b1;
                    if (beat_cnt_r == TAIL_LAST) begin
                        last_tail_s  = 1'b1;
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_TAIL;
                    end
                end else begin
                    state_next_s = ST_TAIL;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Only tail beats 0 and 1 carry encoder-1 termination bits.
    assign tail_chk_s = tail_s & (beat_cnt_r[CNT_W-1:1] == '0);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Beat counter and per-block length latch (K is fixed at beat 0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_r <= '0;
            k_last_r   <= '0;
        end else if (first_s) begin
            beat_cnt_r <= CNT_W'(1);
            k_last_r   <= length_flag ? CNT_W'(K_LONG - 1) : CNT_W'(K_SHORT - 1);
        end else if (last_data_s || last_tail_s) begin
            beat_cnt_r <= '0;
        end else if (data_s || tail_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Data-beat output registers; sys/par hold their last data beat between beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sys_r       <= 1'b0;
            par1_r      <= 1'b0;
            par2_r      <= 1'b0;
            out_valid_r <= 1'b0;
            sob_r       <= 1'b0;
            eob_r       <= 1'b0;
        end else begin
            out_valid_r <= data_s;
            sob_r       <= first_s;
            eob_r       <= last_data_s;
            if (data_s) begin
                sys_r  <= xk;
                par1_r <= zk;
                par2_r <= zkp;
            end else begin
                sys_r  <= sys_r;
                par1_r <= par1_r;
                par2_r <= par2_r;
            end
        end
    end

    // Tail capture: cleared at beat 0, one triplet stored per tail beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tail_bits_r <= 12'h000;
        end else if (first_s) begin
            tail_bits_r <= 12'h000;
        end else if (tail_s) begin
            case (beat_cnt_r[1:0])
                2'd0:    tail_bits_r[2:0]   <= {zkp, zk, xk};
                2'd1:    tail_bits_r[5:3]   <= {zkp, zk, xk};
                2'd2:    tail_bits_r[8:6]   <= {zkp, zk, xk};
                2'd3:    tail_bits_r[11:9]  <= {zkp, zk, xk};
                default: tail_bits_r        <= tail_bits_r;
            endcase
        end else begin
            tail_bits_r <= tail_bits_r;
        end
    end

    // Check results: saturating parity error count and sticky termination error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_cnt_r <= '0;
            term_err_r    <= 1'b0;
        end else if (first_s) begin
            par_err_cnt_r <= ERR_W'(par_mis_s);
            term_err_r    <= 1'b0;
        end else begin
            if (par_mis_s && (par_err_cnt_r != ERR_MAX)) begin
                par_err_cnt_r <= par_err_cnt_r + ERR_W'(1);
            end else begin
                par_err_cnt_r <= par_err_cnt_r;
            end
            term_err_r <= term_err_r | tail_mis_s;
        end
    end

    // Block-completion pulses land in the DONE cycle; busy mirrors DATA/TAIL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tail_valid_r <= 1'b0;
            block_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            tail_valid_r <= last_tail_s;
            block_done_r <= last_tail_s;
            busy_r       <= (state_next_s == ST_DATA) || (state_next_s == ST_TAIL);
        end
    end

    turbo_stream_deframer_rsc_checker u_rsc_checker (
        .clk         (clk),
        .rst         (rst),
        .start       (first_s),
        .data_en     (data_s),
        .tail_chk_en (tail_chk_s),
        .tail_sel    (beat_cnt_r[0]),
        .xk          (xk),
        .zk          (zk),
        .zkp         (zkp),
        .par_mis     (par_mis_s),
        .tail_mis    (tail_mis_s)
    );

    assign sys_bit     = sys_r;
    assign par1_bit    = par1_r;
    assign par2_bit    = par2_r;
    assign out_valid   = out_valid_r;
    assign sob         = sob_r;
    assign eob         = eob_r;
    assign tail_bits   = tail_bits_r;
    assign tail_valid  = tail_valid_r;
    assign par_err_cnt = par_err_cnt_r;
    assign term_err    = term_err_r;
    assign block_done  = block_done_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_turbo_stream_deframer.sv
// Self-checking bench for turbo_stream_deframer. The reference model derives
// the encoder-1 stream from the recursion a[k] = x[k]^a[k-2]^a[k-3],
// z[k] = a[k]^a[k-1]^a[k-3] over a history array.
`timescale 1ns/1ps
module tb_turbo_stream_deframer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, length_flag = 1'b0, xk = 1'b0, zk = 1'b0, zkp = 1'b0;
    logic        sys_bit, par1_bit, par2_bit, out_valid, sob, eob;
    logic [11:0] tail_bits;
    logic        tail_valid, term_err, block_done, busy;
    logic [15:0] par_err_cnt;

    turbo_stream_deframer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .length_flag(length_flag),
        .xk(xk), .zk(zk), .zkp(zkp), .sys_bit(sys_bit), .par1_bit(par1_bit),
        .par2_bit(par2_bit), .out_valid(out_valid), .sob(sob), .eob(eob),
        .tail_bits(tail_bits), .tail_valid(tail_valid), .par_err_cnt(par_err_cnt),
        .term_err(term_err), .block_done(block_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed data beats {sob, eob, sys, par1, par2} and model expectations.
    logic [4:0]  obs_q[$];
    logic [4:0]  exp_q[$];
    int          exp_k, exp_err, busy_low, done_pulses = 0;
    logic        exp_term;
    logic [11:0] exp_tail;
    logic        done_obs, tv_obs, term_obs, done_next_obs, busy_done_obs;
    logic [15:0] err_obs;
    logic [11:0] tail_obs;

    always @(negedge clk) begin
        if (rst && out_valid) obs_q.push_back({sob, eob, sys_bit, par1_bit, par2_bit});
        if (rst && block_done) done_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: got timeout, required completion");
        $fatal(1);
    end

    task automatic drive_beat(input logic lf, input logic [2:0] bits);
        in_valid = 1'b1; length_flag = lf;
        xk = bits[0]; zk = bits[1]; zkp = bits[2];
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Build the model expectations for one block, then drive it.
    task automatic drive_block(input logic lf, input logic lf_late, input logic [5:0] x_bits,
                               input logic [5:0] zflip, input logic [5:0] tcorrupt,
                               input logic [15:0] rbits, input int gap, input logic junk_done);
        logic       a [0:8];
        logic [2:0] beats [0:9];
        logic       zc, s1, s2, s3;
        int         k;
        k = lf ? 6 : 4;
        exp_k = k; exp_err = 0; busy_low = 0;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) a[i] = 1'b0;
        for (int i = 0; i < k; i++) begin
            a[i+3] = x_bits[i] ^ a[i+1] ^ a[i];
            zc     = a[i+3] ^ a[i+2] ^ a[i];
            beats[i] = {rbits[i], zc ^ zflip[i], x_bits[i]};
            if (zflip[i]) exp_err++;
            exp_q.push_back({(i == 0), (i == k - 1), x_bits[i], zc ^ zflip[i], rbits[i]});
        end
        s1 = a[k+2]; s2 = a[k+1]; s3 = a[k];
        beats[k]   = {s1 ^ s2, s1 ^ s3, s2 ^ s3} ^ tcorrupt[2:0];
        beats[k+1] = {s1, s1, s2} ^ tcorrupt[5:3];
        beats[k+2] = rbits[8:6];
        beats[k+3] = rbits[11:9];
        exp_tail = {beats[k+3], beats[k+2], beats[k+1], beats[k]};
        exp_term = |tcorrupt;
        for (int b = 0; b < k + 4; b++) begin
            drive_beat((b == 0) ? lf : lf_late, beats[b]);
            if (b != k + 3) begin
                @(negedge clk);
                if (!busy) busy_low++;
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    if (!busy) busy_low++;
                end
            end
        end
        @(negedge clk);
        done_obs = block_done; tv_obs = tail_valid; err_obs = par_err_cnt;
        term_obs = term_err; tail_obs = tail_bits; busy_done_obs = busy;
        if (junk_done) begin
            in_valid = 1'b1; xk = rbits[12]; zk = rbits[13]; zkp = rbits[14];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        done_next_obs = block_done;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sys_bit, par1_bit, par2_bit, out_valid, sob, eob, tail_valid, term_err, block_done, busy} !== 10'b0) begin
            errors++; $display("FAIL reset_ctrl got %b required 0", {sys_bit, par1_bit, par2_bit, out_valid, sob, eob, tail_valid, term_err, block_done, busy});
        end
        checks++;
        if (tail_bits !== 12'h000 || par_err_cnt !== 16'h0000) begin
            errors++; $display("FAIL reset_data got tail=%h err=%0d required 0/0", tail_bits, par_err_cnt);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got busy=%b ov=%b required 0/0", busy, out_valid);
        end
    endtask

    // Inline comparison of the most recent block against the model.
    task automatic test_block(input string name, input logic lf, input logic lf_late, input logic [5:0] x_bits,
                              input logic [5:0] zflip, input logic [5:0] tcorrupt, input int gap, input logic junk_done);
        logic [15:0] rb;
        rb = 16'($urandom);
        drive_block(lf, lf_late, x_bits, zflip, tcorrupt, rb, gap, junk_done);
        checks++;
        if (obs_q.size() !== exp_k) begin
            errors++; $display("FAIL %s beat_count got %0d required %0d", name, obs_q.size(), exp_k);
        end
        for (int i = 0; i < exp_k && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL %s beat%0d got %b required %b", name, i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (err_obs !== 16'(exp_err) || term_obs !== exp_term) begin
            errors++; $display("FAIL %s checks got err=%0d term=%b required err=%0d term=%b", name, err_obs, term_obs, exp_err, exp_term);
        end
        checks++;
        if (tail_obs !== exp_tail) begin
            errors++; $display("FAIL %s tail_bits got %h required %h", name, tail_obs, exp_tail);
        end
        checks++;
        if ({done_obs, tv_obs, done_next_obs, busy_done_obs} !== 4'b1100) begin
            errors++; $display("FAIL %s done_pulse got %b required 1100", name, {done_obs, tv_obs, done_next_obs, busy_done_obs});
        end
        checks++;
        if (busy_low !== 0) begin
            errors++; $display("FAIL %s busy_dropped got %0d required 0", name, busy_low);
        end
    endtask

    task automatic test_short_block();
        test_block("short_k4", 1'b0, 1'b0, 6'b001101, 6'b000000, 6'b000000, 0, 1'b0);
    endtask

    task automatic test_long_parity_err();
        test_block("long_flip2", 1'b1, 1'b1, 6'($urandom), 6'b000100, 6'b000000, 0, 1'b0);
    endtask

    task automatic test_term_err();
        test_block("term_x0", 1'($urandom), 1'b0, 6'($urandom), 6'b000000, 6'b000001, 0, 1'b0);
        checks++;
        if (tail_obs[0] !== ~(exp_tail[0] ^ 1'b1)) begin
            errors++; $display("FAIL term_x0 tail_bit0 got %b required %b", tail_obs[0], exp_tail[0]);
        end
    endtask

    task automatic test_gaps();
        logic [5:0]  x;
        logic [15:0] rb;
        logic [15:0] err_a;
        logic        term_a;
        logic [11:0] tail_a;
        logic [4:0]  beats_a[$];
        x = 6'($urandom);
        rb = 16'($urandom);
        drive_block(1'b1, 1'b0, x, 6'b010010, 6'b000000, rb, 0, 1'b0);
        err_a = err_obs; term_a = term_obs; tail_a = tail_obs; beats_a = obs_q;
        drive_block(1'b1, 1'b0, x, 6'b010010, 6'b000000, rb, 3, 1'b0);
        checks++;
        if (obs_q !== beats_a || obs_q.size() !== 6) begin
            errors++; $display("FAIL gaps_beats got %0d beats required %0d matching gapless", obs_q.size(), beats_a.size());
        end
        checks++;
        if (err_obs !== err_a || term_obs !== term_a || tail_obs !== tail_a || err_obs !== 16'(exp_err)) begin
            errors++; $display("FAIL gaps_result got err=%0d tail=%h required err=%0d tail=%h", err_obs, tail_obs, exp_err, tail_a);
        end
        checks++;
        if (busy_low !== 0 || done_obs !== 1'b1) begin
            errors++; $display("FAIL gaps_busy got low=%0d done=%b required 0/1", busy_low, done_obs);
        end
    endtask

    task automatic test_reset_mid_block();
        int pulses;
        pulses = done_pulses;
        drive_beat(1'b0, 3'b011);
        drive_beat(1'b0, 3'b101);
        drive_beat(1'b0, 3'b110);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({sys_bit, par1_bit, par2_bit, out_valid, sob, eob, tail_valid, term_err, block_done, busy} !== 10'b0 ||
            tail_bits !== 12'h000 || par_err_cnt !== 16'h0000) begin
            errors++; $display("FAIL mid_reset got ctrl=%b err=%0d required all 0", {sys_bit, par1_bit, par2_bit, out_valid, busy}, par_err_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_pulses !== pulses) begin
            errors++; $display("FAIL mid_reset_done got %0d pulses required %0d", done_pulses, pulses);
        end
        test_block("after_reset", 1'b0, 1'b0, 6'($urandom), 6'b000000, 6'b000000, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_block("b2b_k4", 1'b0, 1'b1, 6'($urandom), 6'b000000, 6'b000000, 0, 1'b1);
        test_block("b2b_k6", 1'b1, 1'b0, 6'($urandom), 6'b100001, 6'b000000, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0] tc;
        for (int n = 0; n < 6; n++) begin
            tc = ($urandom_range(0, 1) == 0) ? 6'b000000 : 6'(1 << $urandom_range(0, 5));
            test_block("random", 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), tc,
                       int'($urandom_range(0, 2)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_short_block();
        test_long_parity_err();
        test_term_err();
        test_gaps();
        test_reset_mid_block();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
